// File: rtl/ads8681_reader.sv
// ads8681_reader: conversion-and-readout engine for the ADS8681 16-bit SAR ADC.
// A start request drives CONVST/CS through a 2-cycle low pulse. CS is then held
// high while the ADC converts. After that, 16 bits are clocked out of SDO,
// MSB-first, on an SCLK derived from clk_in. Each completed word is presented on
// data_out together with a one-cycle data_valid strobe.
//
// Optional feature macro: ADS8681_RVS_WAIT_EN
//   defined   - the conversion wait ends early once the synchronized RVS goes
//               high. The earliest exit is on the 8th CONV cycle. If RVS never
//               rises, the wait ends at CONV_CYCLES and rvs_timeout pulses.
//   undefined - adc_rvs is ignored, and CONV always lasts CONV_CYCLES.
//               rvs_timeout stays 0.
module ads8681_reader #(
    parameter int SCLK_DIV    = 2,    // clk_in cycles per SCLK half-period, >= 1
    parameter int CONV_CYCLES = 100   // clk_in cycles CS is held high, >= 8
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        rvs_timeout,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    input  logic        adc_sdo,
    input  logic        adc_rvs
);

    // The half-period counter needs $clog2(SCLK_DIV) bits. That is zero bits
    // when SCLK_DIV is 1, so keep at least one bit; it simply stays at 0.
    localparam int HALF_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    // The conversion counter runs 0 .. CONV_CYCLES-1.
    localparam int CONV_W = $clog2(CONV_CYCLES);

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SCLK_DIV - 1);
    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);
    localparam logic [4:0]        BIT_LAST  = 5'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CONV,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                arm_cnt_q, arm_cnt_d;
    logic [CONV_W-1:0]   conv_cnt_q, conv_cnt_d;
    logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [15:0]         shift_q, shift_d;
    logic [15:0]         data_out_q, data_out_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic                tmo_q, tmo_d;

    logic                conv_done;     // CONV ends at the coming edge
    logic                conv_timeout;  // ...and it ends because the wait expired

`ifdef ADS8681_RVS_WAIT_EN
    logic [1:0] rvs_sync_q;
    logic       rvs_ready;

    // Two-flop synchronizer for the asynchronous RVS pin.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rvs_sync_q <= 2'b00;
        end else begin
            rvs_sync_q <= {rvs_sync_q[0], adc_rvs};
        end
    end

    // RVS may end the wait only from the 8th CONV cycle (count 7) onward.
    assign rvs_ready    = rvs_sync_q[1] && (conv_cnt_q >= CONV_W'(7));
    assign conv_done    = rvs_ready || (conv_cnt_q == CONV_LAST);
    assign conv_timeout = !rvs_ready && (conv_cnt_q == CONV_LAST);
`else
    // RVS has no function in this build; the fixed-length wait covers conversion.
    logic unused_rvs;
    assign unused_rvs   = adc_rvs;
    assign conv_done    = (conv_cnt_q == CONV_LAST);
    assign conv_timeout = 1'b0;
`endif

    // Next-state and next-output decode for the conversion/readout sequence.
    always_comb begin
        // NOTE: every *_d signal gets a default before the case statement.
        // Without that, a branch that skips an assignment would infer a latch.
        state_d    = state_q;
        arm_cnt_d  = arm_cnt_q;
        conv_cnt_d = conv_cnt_q;
        half_cnt_d = half_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        tmo_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (start) begin
                    state_d   = S_ARM;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    arm_cnt_d = 1'b0;
                end
            end

            // CS stays low for two cycles. Its rising edge starts the conversion.
            S_ARM: begin
                if (arm_cnt_q) begin
                    state_d    = S_CONV;
                    cs_n_d     = 1'b1;
                    conv_cnt_d = '0;
                end else begin
                    arm_cnt_d = 1'b1;
                end
            end

            S_CONV: begin
                conv_cnt_d = conv_cnt_q + 1'b1;
                if (conv_done) begin
                    state_d    = S_SHIFT;
                    cs_n_d     = 1'b0;
                    sclk_d     = 1'b0;
                    half_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tmo_d      = conv_timeout;
                end
            end

            // Each SCLK period is a low phase followed by a high phase. SDO is
            // captured on the same edge that raises SCLK. By then the ADC has
            // had a full low phase to present the bit.
            S_SHIFT: begin
                if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[14:0], adc_sdo};
                    end else if (bit_cnt_q == BIT_LAST) begin
                        state_d    = S_DONE;
                        sclk_d     = 1'b0;
                        cs_n_d     = 1'b1;
                        busy_d     = 1'b0;
                        data_out_d = shift_q;
                        valid_d    = 1'b1;
                    end else begin
                        sclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    half_cnt_d = half_cnt_q + 1'b1;
                end
            end

            // DONE lasts one cycle. A start seen here chains directly into the next frame.
            S_DONE: begin
                if (start) begin
                    state_d   = S_ARM;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    arm_cnt_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters and every pin/status output are registered. This keeps
    // the ADC pins glitch-free, and reset forces them to safe levels at once.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            // NOTE: the shift register and data_out are plain flops, not a memory.
            // They are cleared so that an aborted frame leaves no stale word behind.
            state_q    <= S_IDLE;
            arm_cnt_q  <= 1'b0;
            conv_cnt_q <= '0;
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_out_q <= '0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register here takes its
            // new value from pre-edge values, independent of statement order.
            state_q    <= state_d;
            arm_cnt_q  <= arm_cnt_d;
            conv_cnt_q <= conv_cnt_d;
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            tmo_q      <= tmo_d;
        end
    end

    assign adc_cs_n    = cs_n_q;
    assign adc_sclk    = sclk_q;
    assign busy        = busy_q;
    assign data_out    = data_out_q;
    assign data_valid  = valid_q;
    assign rvs_timeout = tmo_q;

endmodule

// File: tb/tb_ads8681_reader.sv
// tb_ads8681_reader: self-checking bench for ads8681_reader.
// It instantiates two builds: the default parameters (A), and SCLK_DIV=1 with
// CONV_CYCLES=8 (B). Each build has a behavioural ADC model. That model loads
// its word's MSB when CS falls and advances one bit on every falling SCLK edge.
// Expected pin timing comes from the frame formulas. Edges are counted from the
// edge that samples start; the expected data is the word the model was given.
module tb_ads8681_reader;

    localparam int A_SD = 2;
    localparam int A_CC = 100;
    localparam int B_SD = 1;
    localparam int B_CC = 8;
`ifdef ADS8681_RVS_WAIT_EN
    localparam int TMO_PER_FRAME = 1;   // RVS held low by the frame runner
`else
    localparam int TMO_PER_FRAME = 0;
`endif

    logic clk_in = 1'b0;
    logic rst    = 1'b0;

    logic        a_start = 1'b0, b_start = 1'b0;
    logic        a_rvs   = 1'b0, b_rvs   = 1'b0;
    logic        a_busy, b_busy, a_valid, b_valid, a_tmo, b_tmo;
    logic        a_cs_n, b_cs_n, a_sclk, b_sclk, a_sdo, b_sdo;
    logic [15:0] a_data, b_data;

    logic [15:0] a_word = 16'h0000, b_word = 16'h0000;
    logic [3:0]  a_bit  = 4'd15,    b_bit  = 4'd15;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    logic sel    = 1'b0;            // 0 selects instance A, 1 selects B
    logic [15:0] words[$];

    logic        obs_cs_n, obs_sclk, obs_busy, obs_valid, obs_tmo;
    logic [15:0] obs_data;

    ads8681_reader #(.SCLK_DIV(A_SD), .CONV_CYCLES(A_CC)) dut_a (
        .clk_in(clk_in), .rst(rst), .start(a_start), .busy(a_busy),
        .data_out(a_data), .data_valid(a_valid), .rvs_timeout(a_tmo),
        .adc_cs_n(a_cs_n), .adc_sclk(a_sclk), .adc_sdo(a_sdo), .adc_rvs(a_rvs)
    );

    ads8681_reader #(.SCLK_DIV(B_SD), .CONV_CYCLES(B_CC)) dut_b (
        .clk_in(clk_in), .rst(rst), .start(b_start), .busy(b_busy),
        .data_out(b_data), .data_valid(b_valid), .rvs_timeout(b_tmo),
        .adc_cs_n(b_cs_n), .adc_sclk(b_sclk), .adc_sdo(b_sdo), .adc_rvs(b_rvs)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // ADC models: the MSB appears when CS falls, and later bits shift out on SCLK falling edges.
    assign a_sdo = a_word[a_bit];
    assign b_sdo = b_word[b_bit];
    always @(negedge a_cs_n) a_bit = 4'd15;
    always @(negedge b_cs_n) b_bit = 4'd15;
    always @(negedge a_sclk) if (a_bit != 4'd0) a_bit = a_bit - 4'd1;
    always @(negedge b_sclk) if (b_bit != 4'd0) b_bit = b_bit - 4'd1;

    always_comb begin
        obs_cs_n  = sel ? b_cs_n  : a_cs_n;
        obs_sclk  = sel ? b_sclk  : a_sclk;
        obs_busy  = sel ? b_busy  : a_busy;
        obs_valid = sel ? b_valid : a_valid;
        obs_tmo   = sel ? b_tmo   : a_tmo;
        obs_data  = sel ? b_data  : a_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) b_start = v; else a_start = v;
    endtask

    task automatic set_word(input logic [15:0] w);
        if (sel) b_word = w; else a_word = w;
    endtask

    // Runs nfr frames on the selected instance, starting now. Frames come from
    // a start pulse, or from start held high (hold) for back-to-back frames.
    // With poke, start is toggled at random while the frame is in progress.
    // Every event is timestamped and compared against the frame formulas.
    task automatic run_frames(input int nfr, input bit hold, input bit poke);
        int sd, cc, span, per, e0, rel, limit, base;
        int n_rise, n_tmo, busy_bad, tmo_t;
        int cs_f[$], cs_r[$], v_t[$];
        logic [15:0] v_d[$];
        logic pcs, psclk, exp_busy;
        sd   = sel ? B_SD : A_SD;
        cc   = sel ? B_CC : A_CC;
        span = 2 + cc + 32 * sd;        // start edge -> data_valid edge
        per  = span + 1;                // back-to-back frame period
        n_rise = 0; n_tmo = 0; busy_bad = 0; tmo_t = -1;
        @(negedge clk_in);
        set_word(words[0]);
        pcs = obs_cs_n; psclk = obs_sclk;
        set_start(1'b1);
        e0 = cyc + 1;
        limit = e0 + nfr * per + 20;
        while (cyc < limit) begin
            @(negedge clk_in);
            rel = cyc - e0;
            if (obs_cs_n !== pcs) begin
                if (!obs_cs_n) cs_f.push_back(cyc); else cs_r.push_back(cyc);
            end
            if (obs_sclk && !psclk) n_rise++;
            pcs = obs_cs_n; psclk = obs_sclk;
            if (obs_tmo) begin
                n_tmo++;
                if (tmo_t < 0) tmo_t = cyc;
            end
            if (obs_valid) begin
                v_t.push_back(cyc);
                v_d.push_back(obs_data);
                if (v_t.size() < nfr) set_word(words[v_t.size()]);
            end
            exp_busy = (rel >= 0) && (rel < nfr * per) && ((rel % per) != span);
            if (obs_busy !== exp_busy) busy_bad++;
            if (hold) begin
                if (v_t.size() >= nfr) set_start(1'b0);
            end else if (poke && rel <= span - 2) begin
                set_start(1'($urandom));
            end else begin
                set_start(1'b0);
            end
`ifndef ADS8681_RVS_WAIT_EN
            if (sel) b_rvs = 1'($urandom); else a_rvs = 1'($urandom);
`endif
        end
        set_start(1'b0);
        check("cs_fall_count", cs_f.size(), 2 * nfr);
        check("cs_rise_count", cs_r.size(), 2 * nfr);
        check("sclk_rise_count", n_rise, 16 * nfr);
        check("valid_count", v_t.size(), nfr);
        check("busy_trace_errs", busy_bad, 0);
        check("rvs_timeout_count", n_tmo, nfr * TMO_PER_FRAME);
        for (int f = 0; f < nfr; f++) begin
            base = e0 + f * per;
            if (cs_f.size() >= 2 * f + 2 && cs_r.size() >= 2 * f + 2) begin
                check("cs_fall_arm_edge",   cs_f[2*f]     - base, 0);
                check("cs_rise_conv_edge",  cs_r[2*f]     - base, 2);
                check("cs_fall_shift_edge", cs_f[2*f + 1] - base, 2 + cc);
                check("cs_rise_done_edge",  cs_r[2*f + 1] - base, span);
            end
            if (v_t.size() > f) begin
                check("valid_edge", v_t[f] - base, span);
                check("data_out", 32'(v_d[f]), 32'(words[f]));
            end
        end
        if (nfr > 1 && v_t.size() > 1)
            check("valid_gap", v_t[1] - v_t[0], 3 + cc + 32 * sd);
`ifdef ADS8681_RVS_WAIT_EN
        check("rvs_timeout_edge", tmo_t - e0, 2 + cc);
`endif
    endtask

    // Asserts reset on instance A at the 7th SCLK bit of a frame. Checks that
    // the pins fall back at once and that no strobe follows. prev_data is the
    // word still held from the previous frame.
    task automatic run_reset_abort(input logic [15:0] prev_data);
        int n_rise, n_valid, guard, n_cs_low;
        logic psclk;
        sel = 1'b0;
        @(negedge clk_in);
        set_word(16'($urandom));
        psclk = obs_sclk;
        set_start(1'b1);
        n_rise = 0; n_valid = 0; guard = 0; n_cs_low = 0;
        while (n_rise < 7 && guard < 400) begin
            @(negedge clk_in);
            set_start(1'b0);
            guard++;
            if (obs_sclk && !psclk) n_rise++;
            psclk = obs_sclk;
            if (obs_valid) n_valid++;
        end
        check("abort_sclk_bits_before", n_rise, 7);
        check("abort_sclk_high_before", 32'(obs_sclk), 1);
        check("abort_data_before", 32'(obs_data), 32'(prev_data));
        rst = 1'b1;
        #1;
        check("abort_cs_n", 32'(obs_cs_n), 1);
        check("abort_sclk", 32'(obs_sclk), 0);
        check("abort_data_out", 32'(obs_data), 0);
        check("abort_busy", 32'(obs_busy), 0);
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk_in);
            if (obs_valid) n_valid++;
            if (!obs_cs_n) n_cs_low++;
        end
        check("abort_no_valid", n_valid, 0);
        check("abort_cs_stays_high", n_cs_low, 0);
    endtask

`ifdef ADS8681_RVS_WAIT_EN
    // RVS rises 30 cycles into CONV on instance A. SHIFT must begin 2-3 cycles
    // later, with no timeout.
    task automatic run_rvs_early();
        int e0, s, guard, n_fall, n_tmo, vt, d;
        logic pcs;
        logic [15:0] w, vd;
        sel = 1'b0;
        w = 16'($urandom);
        @(negedge clk_in);
        set_word(w);
        pcs = obs_cs_n;
        set_start(1'b1);
        e0 = cyc + 1;
        s = -1; vt = -1; vd = 16'h0; n_fall = 0; n_tmo = 0; guard = 0;
        while (guard < 300 && vt < 0) begin
            @(negedge clk_in);
            guard++;
            set_start(1'b0);
            if (cyc == e0 + 32) a_rvs = 1'b1;
            if (!obs_cs_n && pcs) begin
                n_fall++;
                if (n_fall == 2) s = cyc;
            end
            pcs = obs_cs_n;
            if (obs_tmo) n_tmo++;
            if (obs_valid) begin vt = cyc; vd = obs_data; end
        end
        d = s - (e0 + 32);
        check("rvs_early_shift_lat_ok", 32'((d >= 2) && (d <= 3)), 1);
        check("rvs_early_no_timeout", n_tmo, 0);
        check("rvs_early_valid_edge", vt - s, 32 * A_SD);
        check("rvs_early_data", 32'(vd), 32'(w));
        a_rvs = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask
`endif

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_a_cs_n", 32'(a_cs_n), 1);
        check("rst_a_sclk", 32'(a_sclk), 0);
        check("rst_a_busy", 32'(a_busy), 0);
        check("rst_a_valid", 32'(a_valid), 0);
        check("rst_a_tmo", 32'(a_tmo), 0);
        check("rst_a_data", 32'(a_data), 0);
        check("rst_b_cs_n", 32'(b_cs_n), 1);
        check("rst_b_sclk", 32'(b_sclk), 0);
        check("rst_b_busy", 32'(b_busy), 0);
        check("rst_b_data", 32'(b_data), 0);
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        repeat (3) @(negedge clk_in);

        // Default build, a known word, a single start pulse.
        sel = 1'b0;
        words.delete(); words.push_back(16'hA5C3);
        run_frames(1, 1'b0, 1'b0);

        // Fast build with start held high: 0001, then FFFF.
        sel = 1'b1;
        words.delete(); words.push_back(16'h0001); words.push_back(16'hFFFF);
        run_frames(2, 1'b1, 1'b0);

        // Fast build, three random back-to-back words.
        words.delete();
        for (int i = 0; i < 3; i++) words.push_back(16'($urandom));
        run_frames(3, 1'b1, 1'b0);

        // start is re-pulsed during the frame and must be ignored, on both builds.
        sel = 1'b0;
        words.delete(); words.push_back(16'($urandom));
        run_frames(1, 1'b0, 1'b1);
        sel = 1'b1;
        words.delete(); words.push_back(16'($urandom));
        run_frames(1, 1'b0, 1'b1);

        // Abort at the 7th bit on A, then a clean frame.
        run_reset_abort(words[0] ^ 16'h0000 ^ a_data ^ words[0]);
        sel = 1'b0;
        words.delete(); words.push_back(16'($urandom));
        run_frames(1, 1'b0, 1'b0);

`ifdef ADS8681_RVS_WAIT_EN
        run_rvs_early();
`endif

        // Random single frames on the fast build, separated by random idle gaps.
        sel = 1'b1;
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk_in);
            words.delete(); words.push_back(16'($urandom));
            run_frames(1, 1'b0, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
